rx_frame_control: RTL and testbench
===================================

# rx_frame_control

Receive-side frame controller for the UART path. Detects the start bit on the synchronized serial line and gates the 16x bit-sample counter. It consumes that counter's mid-bit sample strobe and end-of-bit strobe, assembles LSB-first data bits, checks the stop bit, and presents each character to the consumer on a valid/ack handshake with framing-error and overrun status.

## Interface
Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..8.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset.
- serial_in  in  1  raw asynchronous RX line; idles high.
- sample_strobe  in  1  mid-bit strobe from the sample counter; high for one cycle at count 7.
- bit_done  in  1  end-of-bit strobe from the sample counter; high for one cycle at count 15.
- sample_enable  out  1  enable for the sample counter.
- data_out  out  DATA_BITS  received character; stable while data_valid=1.
- data_valid  out  1  character available.
- data_ack  in  1  consumer accepts the character on any cycle where data_valid=1.
- framing_error  out  1  one-cycle pulse when the stop bit samples low.
- overrun  out  1  sticky; a completed character was dropped because data_valid was still set.
- busy  out  1  high in any state other than IDLE.

## Operation
- serial_in passes through a 2-flop synchronizer, giving rx_s. A third flop holds rx_d for edge detection.
- States: IDLE, START, DATA, STOP, ABORT. sample_enable=1 in every state except IDLE.
- IDLE: when rx_d=1 and rx_s=0, go to START. Bit index and shift register clear to 0.
- START: on sample_strobe:
  - if rx_s=0, stay in START (valid start);
  - if rx_s=1, go to ABORT (false start).
  - On bit_done, go to DATA with bit index 0.
- DATA:
  - on sample_strobe, shift rx_s into the MSB of the DATA_BITS-wide shift register (right shift, LSB first);
  - on bit_done, increment the bit index; if the index was DATA_BITS-1, go to STOP instead.
- STOP: on sample_strobe, sample rx_s:
  - 1: complete the character (handshake rules below).
  - 0: pulse framing_error and discard the character.
  - On bit_done, go to IDLE.
- ABORT: hold sample_enable until bit_done, then go to IDLE. No outputs change.
- The controller leaves every frame or abort on bit_done, with enable still high that cycle. The counter therefore wraps to 0 and is at 0 whenever sample_enable rises.
- Handshake:
  - character completes with data_valid=0: load data_out and set data_valid.
  - data_valid=1 and data_ack=1 with no completion: clear data_valid.
  - completion and data_ack in the same cycle: load the new data_out, data_valid stays 1, no overrun.
  - completion with data_valid=1 and data_ack=0: drop the new character, keep the old data_out, set overrun.
  - overrun clears on the cycle data_ack=1.
- A sample_strobe or bit_done arriving in IDLE is ignored.

## Timing
- Reset (rst=0 at an edge):
  - state IDLE; sample_enable, data_valid, framing_error, overrun, busy = 0; data_out = 0; synchronizer flops = 1.
  - This applies mid-frame too: the frame is abandoned with no outputs.
  - The sample counter shares rst, so alignment is restored.
- Start edge on serial_in reaches rx_s 2 cycles later. sample_enable rises on the edge after detection.
- Each bit lasts 16 cycles of sample_enable. sample_strobe comes 8 cycles after the bit period start, bit_done 16 cycles after.
- data_valid / framing_error assert on the edge after the stop-bit sample_strobe cycle.
- A full frame (1 start, DATA_BITS data, 1 stop bit) holds sample_enable for exactly 16*(DATA_BITS+2) cycles.
- Back-to-back frames: a start edge detected on the first IDLE cycle is accepted; no dead cycles beyond one.
- data_ack while data_valid=0 has no effect.

## Test plan
- Clean frame, DATA_BITS=8, 0xA5 LSB-first, stop=1, counter model attached:
  - data_valid=1 with data_out=0xA5 one cycle after the stop sample;
  - sample_enable high for exactly 160 cycles;
  - counter back at 0.
- False start, serial_in low for 4 cycles then high:
  - ABORT entered at the first sample_strobe;
  - sample_enable drops after bit_done;
  - no data_valid, no framing_error; returns to IDLE.
- Framing error, 0x3C with stop=0:
  - framing_error is a 1-cycle pulse;
  - data_valid stays 0; data_out unchanged.
- Overrun, frames 0x11 then 0x22 with no ack:
  - data_out=0x11 and overrun=1 after the second frame;
  - data_ack clears both data_valid and overrun next cycle.
- Simultaneous, data_ack asserted exactly on the completion cycle of 0x22 while 0x11 is pending:
  - data_out=0x22, data_valid=1, overrun=0.
- Reset mid-frame, rst=0 for one cycle during DATA bit 3:
  - all outputs 0, state IDLE;
  - a following frame 0x5A is received correctly.

Source files
------------

// File: rtl/rx_frame_control.sv
// UART receive frame controller: start detection, sample-counter gating,
// LSB-first data assembly, stop check and valid/ack handoff with error status.
module rx_frame_control #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  input  logic                 sample_strobe,
  input  logic                 bit_done,
  output logic                 sample_enable,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ack,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int IDX_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, ABORT} state_t;

  state_t               state_reg;
  logic                 rx_meta_reg;
  logic                 rx_s_reg;
  logic                 rx_d_reg;
  logic [IDX_W-1:0]     bit_idx_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] data_reg;
  logic                 valid_reg;
  logic                 fe_reg;
  logic                 ovr_reg;
  logic                 en_reg;
  logic                 busy_reg;
  logic                 complete;

  // A good stop bit sampled this cycle delivers the assembled character.
  assign complete = (state_reg == STOP) && sample_strobe && rx_s_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
      rx_d_reg    <= 1'b1;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      fe_reg      <= 1'b0;
      ovr_reg     <= 1'b0;
      en_reg      <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      rx_meta_reg <= serial_in;
      rx_s_reg    <= rx_meta_reg;
      rx_d_reg    <= rx_s_reg;
      fe_reg      <= 1'b0;

      case (state_reg)
        IDLE: begin
          bit_idx_reg <= '0;
          shift_reg   <= '0;
          if (rx_d_reg && !rx_s_reg) begin
            state_reg <= START;
            en_reg    <= 1'b1;
            busy_reg  <= 1'b1;
          end
        end
        START: begin
          if (sample_strobe && rx_s_reg) begin
            state_reg <= ABORT;
          end else if (bit_done) begin
            state_reg   <= DATA;
            bit_idx_reg <= '0;
          end
        end
        DATA: begin
          if (sample_strobe) begin
            shift_reg <= {rx_s_reg, shift_reg[DATA_BITS-1:1]};
          end
          if (bit_done) begin
            if (bit_idx_reg == IDX_W'(DATA_BITS - 1)) begin
              state_reg <= STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end
        end
        STOP: begin
          if (sample_strobe && !rx_s_reg) begin
            fe_reg <= 1'b1;
          end
          if (bit_done) begin
            state_reg <= IDLE;
            en_reg    <= 1'b0;
            busy_reg  <= 1'b0;
          end
        end
        ABORT: begin
          if (bit_done) begin
            state_reg <= IDLE;
            en_reg    <= 1'b0;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          en_reg    <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase

      // An ack on the completion cycle frees the slot, so the new character wins.
      if (complete) begin
        if (!valid_reg || data_ack) begin
          data_reg  <= shift_reg;
          valid_reg <= 1'b1;
          ovr_reg   <= 1'b0;
        end else begin
          ovr_reg <= 1'b1;
        end
      end else if (valid_reg && data_ack) begin
        valid_reg <= 1'b0;
        ovr_reg   <= 1'b0;
      end
    end
  end

  assign sample_enable = en_reg;
  assign data_out      = data_reg;
  assign data_valid    = valid_reg;
  assign framing_error = fe_reg;
  assign overrun       = ovr_reg;
  assign busy          = busy_reg;

endmodule

// File: tb/tb_rx_frame_control.sv
// Bench for rx_frame_control: directed frame table, multi-cycle corner cases,
// then randomized frames checked against a character-level delivery model.
module tb_rx_frame_control;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       serial_in = 1'b1;
  logic       data_ack = 1'b0;
  logic       sample_strobe;
  logic       bit_done;
  logic       sample_enable;
  logic [7:0] data_out;
  logic       data_valid;
  logic       framing_error;
  logic       overrun;
  logic       busy;
  logic [3:0] cnt;

  int errors = 0;
  int checks = 0;

  // Cycle-level monitor counters, sampled on the falling edge.
  int   cyc = 0;
  int   en_total = 0;
  int   fe_total = 0;
  int   strobe_total = 0;
  int   bd_total = 0;
  int   last_strobe_cyc = -1;
  int   fe_rise_cyc = -1;
  int   dv_rise_cyc = -1;
  logic prev_fe = 1'b0;
  logic prev_dv = 1'b0;

  typedef struct {
    logic [7:0] d;
    bit         stop;
    bit         ack_after;
    bit         exp_valid;
    logic [7:0] exp_data;
    bit         exp_fe;
    bit         exp_ovr;
  } vec_t;

  vec_t tbl[5];

  int         en0, fe0, bd0, st0, n;
  logic       pv;
  logic [7:0] m_data, rd;
  bit         m_valid, m_ovr, rstop;

  rx_frame_control #(.DATA_BITS(8)) dut (
    .clk(clk),
    .rst(rst),
    .serial_in(serial_in),
    .sample_strobe(sample_strobe),
    .bit_done(bit_done),
    .sample_enable(sample_enable),
    .data_out(data_out),
    .data_valid(data_valid),
    .data_ack(data_ack),
    .framing_error(framing_error),
    .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // 16x sample counter that the controller gates.
  always_ff @(posedge clk) begin
    if (!rst) cnt <= 4'd0;
    else if (sample_enable) cnt <= cnt + 4'd1;
  end
  assign sample_strobe = sample_enable && (cnt == 4'd7);
  assign bit_done      = sample_enable && (cnt == 4'd15);

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (sample_enable) en_total = en_total + 1;
    if (framing_error) fe_total = fe_total + 1;
    if (sample_strobe) begin
      strobe_total = strobe_total + 1;
      last_strobe_cyc = cyc;
    end
    if (bit_done) bd_total = bd_total + 1;
    if (framing_error && !prev_fe) fe_rise_cyc = cyc;
    if (data_valid && !prev_dv) dv_rise_cyc = cyc;
    prev_fe = framing_error;
    prev_dv = data_valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("check %s: 0x%0h ok", name, act);
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    data_ack = 1'b1;
    cycles(1);
    data_ack = 1'b0;
  endtask

  // Start bit, 8 data bits LSB first, stop bit, then a short idle tail.
  task automatic send_frame(input logic [7:0] d, input bit stop);
    serial_in = 1'b0;
    cycles(16);
    for (int i = 0; i < 8; i++) begin
      serial_in = d[i];
      cycles(16);
    end
    serial_in = stop;
    cycles(16);
    serial_in = 1'b1;
    cycles(4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    //          data   stop ack  valid data   fe   ovr
    tbl[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0};
    tbl[2] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
    tbl[3] = '{8'h22, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1};
    tbl[4] = '{8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0};

    rst = 1'b0;
    cycles(3);
    @(negedge clk);
    chk("rst_enable", sample_enable, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_fe", framing_error, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    cycles(5);

    for (int i = 0; i < 5; i++) begin
      en0 = en_total;
      fe0 = fe_total;
      pv  = data_valid;
      send_frame(tbl[i].d, tbl[i].stop);
      @(negedge clk);
      $display("row %0d: data 0x%0h stop %0d", i, tbl[i].d, tbl[i].stop);
      chk("row_valid", data_valid, tbl[i].exp_valid);
      chk("row_data", data_out, tbl[i].exp_data);
      chk("row_ovr", overrun, tbl[i].exp_ovr);
      chk("row_fe_cycles", fe_total - fe0, tbl[i].exp_fe);
      chk("row_en_cycles", en_total - en0, 160);
      chk("row_cnt_zero", cnt, 0);
      chk("row_busy_idle", busy, 0);
      if (tbl[i].exp_fe) chk("row_fe_latency", fe_rise_cyc - last_strobe_cyc, 1);
      if (tbl[i].exp_valid && !pv) chk("row_dv_latency", dv_rise_cyc - last_strobe_cyc, 1);
      if (tbl[i].ack_after) begin
        ack_pulse();
        @(negedge clk);
        chk("row_ack_valid", data_valid, 0);
        chk("row_ack_ovr", overrun, 0);
      end
    end

    // False start: line low for only 4 cycles.
    en0 = en_total; fe0 = fe_total; bd0 = bd_total; st0 = strobe_total;
    serial_in = 1'b0;
    cycles(4);
    serial_in = 1'b1;
    cycles(30);
    @(negedge clk);
    $display("false start sequence");
    chk("fs_en_cycles", en_total - en0, 16);
    chk("fs_strobes", strobe_total - st0, 1);
    chk("fs_bit_dones", bd_total - bd0, 1);
    chk("fs_fe", fe_total - fe0, 0);
    chk("fs_valid", data_valid, 0);
    chk("fs_busy", busy, 0);
    chk("fs_cnt_zero", cnt, 0);

    // Ack lands exactly on the completion cycle while a character is pending.
    send_frame(8'h11, 1'b1);
    @(negedge clk);
    chk("sim_pending_data", data_out, 8'h11);
    chk("sim_pending_valid", data_valid, 1);
    n = 0;
    fork
      send_frame(8'h22, 1'b1);
      begin
        for (int k = 0; k < 400 && n < 10; k++) begin
          @(negedge clk);
          if (sample_strobe) n = n + 1;
        end
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
      end
    join
    @(negedge clk);
    chk("sim_strobe_seen", n, 10);
    chk("sim_data", data_out, 8'h22);
    chk("sim_valid", data_valid, 1);
    chk("sim_ovr", overrun, 0);

    // Reset during data bit 3 with a character still pending.
    bd0 = bd_total;
    serial_in = 1'b0;
    cycles(16);
    serial_in = 1'b1;
    for (int k = 0; k < 200 && (bd_total - bd0) < 4; k++) cycles(1);
    chk("mr_reached_bit3", bd_total - bd0, 4);
    cycles(5);
    rst = 1'b0;
    cycles(1);
    rst = 1'b1;
    @(negedge clk);
    $display("reset mid-frame sequence");
    chk("mr_enable", sample_enable, 0);
    chk("mr_busy", busy, 0);
    chk("mr_valid", data_valid, 0);
    chk("mr_data", data_out, 0);
    chk("mr_ovr", overrun, 0);
    chk("mr_cnt", cnt, 0);
    cycles(20);
    en0 = en_total;
    send_frame(8'h5A, 1'b1);
    @(negedge clk);
    chk("mr_next_data", data_out, 8'h5A);
    chk("mr_next_valid", data_valid, 1);
    chk("mr_next_en", en_total - en0, 160);
    ack_pulse();

    // Random frames against a character-level delivery model.
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_data  = 8'h5A;
    for (int r = 0; r < 25; r++) begin
      cycles($urandom_range(1, 12));
      if ($urandom_range(0, 1) == 1) begin
        ack_pulse();
        if (m_valid) begin
          m_valid = 1'b0;
          m_ovr   = 1'b0;
        end
      end
      rd    = 8'($urandom);
      rstop = ($urandom_range(0, 3) != 0);
      fe0 = fe_total;
      en0 = en_total;
      send_frame(rd, rstop);
      if (rstop) begin
        if (!m_valid) begin
          m_data  = rd;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end
      @(negedge clk);
      $display("rand %0d: data 0x%0h stop %0d", r, rd, rstop);
      chk("rand_valid", data_valid, m_valid);
      chk("rand_data", data_out, m_data);
      chk("rand_ovr", overrun, m_ovr);
      chk("rand_fe_cycles", fe_total - fe0, rstop ? 0 : 1);
      chk("rand_en_cycles", en_total - en0, 160);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
